regbank_streamer: RTL and testbench
===================================

# regbank_streamer

Burst read-out engine for the register bank. It takes the bank's full parallel contents, walks a caller-selected run of consecutive addresses, and emits one word per accepted transfer on a valid/ready stream. It sits beside the bank as its reader, for example to dump state to a debug/UART path or to feed a DMA-style consumer, and does not touch the bank's write port.

## Interface
- ADDR_WIDTH, 12, bank address width
- WORD_WIDTH, 32, bank word width
- SIZE, 1<<ADDR_WIDTH, number of bank entries
- i_clk  in  1  sole clock, rising edge
- i_rst  in  1  reset, asynchronous and active-high
- i_bank  in  WORD_WIDTH x SIZE  unpacked array, live bank contents
- i_start  in  1  request a burst; sampled only in IDLE
- i_base  in  ADDR_WIDTH  first address of burst
- i_count  in  ADDR_WIDTH+1  words to emit, 0..SIZE
- o_data  out  WORD_WIDTH  current word
- o_valid  out  1  o_data holds a word not yet accepted
- i_ready  in  1  consumer accepts when o_valid&i_ready
- o_last  out  1  current word is the final one of the burst
- o_busy  out  1  high in any state other than IDLE
- o_done  out  1  one-cycle pulse when a burst completes

## Operation
- States: IDLE, STREAM, DONE.
- IDLE with i_start=1 and i_count>0:
  - Capture r_addr=i_base and r_remaining=i_count.
  - Load o_data<=i_bank[i_base].
  - Go to STREAM.
- IDLE with i_start=1 and i_count=0: go to DONE directly. No word is emitted.
- STREAM:
  - o_valid=1. o_last=(r_remaining==1).
  - On handshake with r_remaining>1: r_addr<=r_addr+1, wrapping modulo SIZE. Load o_data<=i_bank[r_addr+1]. Decrement r_remaining.
  - On handshake with r_remaining==1: go to DONE.
- DONE: o_done=1, o_valid=0, o_last=0. Next cycle go to IDLE.
- i_start is ignored in STREAM and DONE. i_base and i_count are only sampled on the accepting edge.
- Snapshot rule: each word is the value of i_bank at the edge where it is loaded into o_data. Bank writes after that edge do not change the word already presented.
- Address arithmetic is unsigned ADDR_WIDTH and wraps: after SIZE-1 comes 0.
- i_count>SIZE is out of contract and has no defined behaviour.
- Reset, including reset in mid-burst:
  - State returns to IDLE.
  - o_data=0, o_valid=0, o_last=0, o_busy=0, o_done=0, r_addr=0, r_remaining=0.
  - An aborted burst produces no o_done.

## Timing
- Start latency: i_start accepted at edge N, so o_valid=1 with word 0 from edge N onward, i.e. visible in cycle N+1.
- Throughput: one word per cycle while i_ready is held high. No bubbles inside a burst.
- Backpressure: while o_valid=1 and i_ready=0, o_data and o_last hold stable.
- o_valid never drops without a handshake, except on reset.
- Completion: the final handshake at edge M gives o_done=1 in cycle M+1. o_busy falls after edge M+1.
- Earliest next burst: a new i_start is accepted at edge M+2, since start is sampled in IDLE only.
- Zero-count burst: i_start at edge N gives o_done=1 in cycle N+1, with o_valid staying 0.

## Test plan
- Basic burst: preload bank[5..7]=0xA,0xB,0xC, pulse i_start with base=5, count=3, i_ready=1 throughout.
  - Words 0xA,0xB,0xC appear on consecutive cycles.
  - o_last is high only with 0xC.
  - o_done pulses one cycle after the 0xC handshake.
- Backpressure: same burst with i_ready low for 4 cycles on the second word.
  - 0xB and o_last=0 hold stable for those 4 cycles.
  - Exactly 3 handshakes in total, in order.
- Wrap-around: set ADDR_WIDTH=3, bank[i]=i+0x10, base=6, count=4.
  - Output sequence is 0x16,0x17,0x10,0x11.
- Full bank and zero count:
  - ADDR_WIDTH=3, count=8: all 8 entries are emitted once.
  - count=0: o_done fires the cycle after i_start, with o_valid never asserted.
- Ignored start and snapshot:
  - Pulse i_start with a different base in mid-burst: the stream is unaffected.
  - Write bank[r_addr] while its word is stalled: the presented word is unchanged.
  - Write the next address before it loads: the new value is emitted.
- Reset mid-burst: assert i_rst during the second word.
  - All outputs go to 0 immediately, with no o_done.
  - After release, a fresh burst runs correctly.

Source files
------------

// File: rtl/regbank_streamer.sv
// regbank_streamer
//
// Burst read-out engine for the register bank. Given the bank's full parallel
// contents, it walks a run of consecutive addresses starting at i_base
// (wrapping modulo SIZE) and presents one word per valid/ready handshake.
// The engine only reads the bank and never drives its write port.
//
// Ports:
//   i_clk      rising-edge clock
//   i_rst      asynchronous, active-high reset
//   i_bank     live bank contents, one word per address
//   i_start    burst request, looked at only while idle
//   i_base     first address of the burst
//   i_count    number of words to emit (0..SIZE)
//   o_data     word currently presented
//   o_valid    o_data holds a word that has not been accepted yet
//   i_ready    consumer accepts the word when o_valid & i_ready
//   o_last     the presented word is the final one of the burst
//   o_busy     engine is not idle
//   o_done     one-cycle pulse after the final handshake (or a zero-count start)

module regbank_streamer #(
  parameter int ADDR_WIDTH = 12,
  parameter int WORD_WIDTH = 32,
  parameter int SIZE       = 1 << ADDR_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [WORD_WIDTH-1:0] i_bank [SIZE],
  input  logic                  i_start,
  input  logic [ADDR_WIDTH-1:0] i_base,
  input  logic [ADDR_WIDTH:0]   i_count,
  output logic [WORD_WIDTH-1:0] o_data,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic                  o_last,
  output logic                  o_busy,
  output logic                  o_done
);

  typedef enum logic [1:0] {
    IDLE,
    STREAM,
    DONE
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH:0]   remaining_q, remaining_d;
  logic [WORD_WIDTH-1:0] data_q, data_d;

  // Next address wraps naturally because it is kept at ADDR_WIDTH bits.
  logic [ADDR_WIDTH-1:0] addr_inc;
  assign addr_inc = addr_q + ADDR_WIDTH'(1);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      remaining_q <= '0;
      data_q      <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      remaining_q <= remaining_d;
      data_q      <= data_d;
    end
  end

  // The word register is loaded from the bank at the edge that selects the
  // address, so later bank writes never disturb a word already presented.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    remaining_d = remaining_q;
    data_d      = data_q;
    o_valid     = 1'b0;
    o_last      = 1'b0;
    o_busy      = 1'b1;
    o_done      = 1'b0;

    case (state_q)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          if (i_count != '0) begin
            addr_d      = i_base;
            remaining_d = i_count;
            data_d      = i_bank[i_base];
            state_d     = STREAM;
          end else begin
            state_d = DONE;
          end
        end
      end

      STREAM: begin
        o_valid = 1'b1;
        o_last  = (remaining_q == (ADDR_WIDTH+1)'(1));
        if (i_ready) begin
          remaining_d = remaining_q - (ADDR_WIDTH+1)'(1);
          if (remaining_q > (ADDR_WIDTH+1)'(1)) begin
            addr_d = addr_inc;
            data_d = i_bank[addr_inc];
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        o_done  = 1'b1;
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign o_data = data_q;

endmodule

// File: tb/tb_regbank_streamer.sv
// tb_regbank_streamer
//
// Bench for regbank_streamer built with an 8-entry bank (ADDR_WIDTH=3).
// A cycle-by-cycle vector table covers a plain burst, a zero-count start and
// a backpressured burst; hand-written sequences cover wrap-around, a full
// bank sweep, ignored starts, the snapshot rule and reset in mid-burst.

module tb_regbank_streamer;

  localparam int AW = 3;
  localparam int WW = 32;
  localparam int SZ = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [WW-1:0] bank [SZ];
  logic          start;
  logic [AW-1:0] base;
  logic [AW:0]   count;
  logic          ready;
  logic [WW-1:0] data;
  logic          valid;
  logic          last;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;
  int handshakes;

  regbank_streamer #(
    .ADDR_WIDTH(AW),
    .WORD_WIDTH(WW),
    .SIZE(SZ)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_bank(bank),
    .i_start(start),
    .i_base(base),
    .i_count(count),
    .o_data(data),
    .o_valid(valid),
    .i_ready(ready),
    .o_last(last),
    .o_busy(busy),
    .o_done(done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          start;
    logic [AW-1:0] base;
    logic [AW:0]   count;
    logic          ready;
    logic          valid;
    logic [WW-1:0] data;
    logic          last;
    logic          busy;
    logic          done;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mkVec(input logic s, input logic [AW-1:0] b,
                                 input logic [AW:0] c, input logic r,
                                 input logic v, input logic [WW-1:0] d,
                                 input logic l, input logic bz, input logic dn);
    vec_t t;
    t.start = s; t.base = b; t.count = c; t.ready = r;
    t.valid = v; t.data = d; t.last = l; t.busy = bz; t.done = dn;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [AW-1:0] b,
                               input logic [AW:0] c, input logic r);
    start = s;
    base  = b;
    count = c;
    ready = r;
  endtask

  // Advance one clock and move to a sampling point just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Start a burst with i_ready held high and compare every presented word
  // against the expected list, bounding the wait for o_done.
  task automatic runBurst(input string name, input logic [AW-1:0] b,
                          input logic [AW:0] c, input logic [WW-1:0] exp_words[$]);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    applyStimulus(1'b1, b, c, 1'b1);
    tick();
    applyStimulus(1'b0, '0, '0, 1'b1);
    while (!done && cyc < 40) begin
      if (valid) begin
        if (k < exp_words.size()) begin
          checkOutput($sformatf("%s word%0d", name, k), data, exp_words[k]);
          checkOutput($sformatf("%s last%0d", name, k), 32'(last),
                      32'(k == exp_words.size() - 1));
        end
        k++;
      end
      tick();
      cyc++;
    end
    checkOutput($sformatf("%s done", name), 32'(done), 32'd1);
    checkOutput($sformatf("%s valid_at_done", name), 32'(valid), 32'd0);
    checkOutput($sformatf("%s words", name), 32'(k), 32'(exp_words.size()));
    tick();
    checkOutput($sformatf("%s idle", name), 32'(busy), 32'd0);
  endtask

  initial begin
    logic [WW-1:0] q[$];

    rst = 1'b1;
    applyStimulus(1'b0, '0, '0, 1'b0);
    for (int i = 0; i < SZ; i++) bank[i] = WW'(i + 'h10);
    bank[5] = 32'hA;
    bank[6] = 32'hB;
    bank[7] = 32'hC;

    // Reset state
    tick();
    checkOutput("reset data", data, 32'd0);
    checkOutput("reset valid", 32'(valid), 32'd0);
    checkOutput("reset last", 32'(last), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();

    // Basic burst, zero count, backpressured burst
    vecs[0]  = mkVec(1'b1, 3'd5, 4'd3, 1'b1, 1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
    vecs[1]  = mkVec(1'b0, 3'd0, 4'd0, 1'b1, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    vecs[2]  = mkVec(1'b0, 3'd0, 4'd0, 1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    vecs[3]  = mkVec(1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    vecs[4]  = mkVec(1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    vecs[5]  = mkVec(1'b1, 3'd5, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    vecs[6]  = mkVec(1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    vecs[7]  = mkVec(1'b1, 3'd5, 4'd3, 1'b1, 1'b1, 32'hA, 1'b0, 1'b1, 1'b0);
    vecs[8]  = mkVec(1'b0, 3'd0, 4'd0, 1'b1, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    vecs[9]  = mkVec(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    vecs[10] = mkVec(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    vecs[11] = mkVec(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    vecs[12] = mkVec(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 32'hB, 1'b0, 1'b1, 1'b0);
    vecs[13] = mkVec(1'b0, 3'd0, 4'd0, 1'b1, 1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    vecs[14] = mkVec(1'b0, 3'd0, 4'd0, 1'b0, 1'b1, 32'hC, 1'b1, 1'b1, 1'b0);
    vecs[15] = mkVec(1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
    vecs[16] = mkVec(1'b0, 3'd0, 4'd0, 1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);

    handshakes = 0;
    for (int i = 0; i < 17; i++) begin
      applyStimulus(vecs[i].start, vecs[i].base, vecs[i].count, vecs[i].ready);
      if (valid && ready) handshakes++;
      tick();
      checkOutput($sformatf("vec%0d valid", i), 32'(valid), 32'(vecs[i].valid));
      if (vecs[i].valid) checkOutput($sformatf("vec%0d data", i), data, vecs[i].data);
      checkOutput($sformatf("vec%0d last", i), 32'(last), 32'(vecs[i].last));
      checkOutput($sformatf("vec%0d busy", i), 32'(busy), 32'(vecs[i].busy));
      checkOutput($sformatf("vec%0d done", i), 32'(done), 32'(vecs[i].done));
    end
    checkOutput("table handshakes", 32'(handshakes), 32'd6);

    // Wrap-around and full-bank sweeps
    for (int i = 0; i < SZ; i++) bank[i] = WW'(i + 'h10);
    q = '{32'h16, 32'h17, 32'h10, 32'h11};
    runBurst("wrap", 3'd6, 4'd4, q);
    q = '{32'h13, 32'h14, 32'h15, 32'h16, 32'h17, 32'h10, 32'h11, 32'h12};
    runBurst("full", 3'd3, 4'd8, q);
    q = {};
    runBurst("zero", 3'd2, 4'd0, q);

    // A start pulse in mid-burst with a different base is ignored
    q = '{32'h10, 32'h11, 32'h12, 32'h13};
    applyStimulus(1'b1, 3'd0, 4'd4, 1'b1);
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("ignstart word%0d", i), data, q[i]);
      checkOutput($sformatf("ignstart valid%0d", i), 32'(valid), 32'd1);
      if (i == 0) applyStimulus(1'b1, 3'd5, 4'd2, 1'b1);
      else        applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
      tick();
    end
    checkOutput("ignstart done", 32'(done), 32'd1);
    tick();

    // Snapshot: stalled word is frozen, next word picks up a fresh write
    applyStimulus(1'b1, 3'd2, 4'd3, 1'b0);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b0);
    checkOutput("snap first", data, 32'h12);
    bank[2] = 32'hDEAD;
    tick();
    checkOutput("snap held", data, 32'h12);
    bank[3] = 32'hBEEF;
    ready = 1'b1;
    tick();
    checkOutput("snap next", data, 32'hBEEF);
    tick();
    checkOutput("snap third", data, 32'h14);
    checkOutput("snap last", 32'(last), 32'd1);
    tick();
    checkOutput("snap done", 32'(done), 32'd1);
    tick();
    bank[2] = 32'h12;
    bank[3] = 32'h13;

    // Reset during the second word
    applyStimulus(1'b1, 3'd0, 4'd3, 1'b1);
    tick();
    applyStimulus(1'b0, 3'd0, 4'd0, 1'b1);
    tick();
    checkOutput("rstmid word1", data, 32'h11);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid data", data, 32'd0);
    checkOutput("rstmid valid", 32'(valid), 32'd0);
    checkOutput("rstmid last", 32'(last), 32'd0);
    checkOutput("rstmid busy", 32'(busy), 32'd0);
    checkOutput("rstmid done", 32'(done), 32'd0);
    tick();
    checkOutput("rstmid no_done", 32'(done), 32'd0);
    rst = 1'b0;
    tick();
    checkOutput("rstmid idle_done", 32'(done), 32'd0);
    q = '{32'h11, 32'h12, 32'h13};
    runBurst("after_rst", 3'd1, 4'd3, q);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
